ir_seq_ctrl: RTL

Parametrised successor to the basic instruction register. It owns the sequence counter (SC) and its one-hot timing signals T, and loads the instruction register at a configurable timing step. At a later step it latches the decoded opcode (one-hot D), the indirect bit I and the address field. It is the front end of the control unit and feeds D/I/T to the control-logic gates and ADDR toward AR.

---
 rtl/mano_pkg.sv | 22 ++
 rtl/seq_counter.sv | 40 ++++
 rtl/ir_seq_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/mano_pkg.sv
// Shared constants and helpers for the basic-computer control unit.
// Default datapath widths, fetch/decode timing steps and a one-hot decoder.
package mano_pkg;

  localparam int unsigned WORD_W_DEF = 16;
  localparam int unsigned OP_W_DEF   = 3;
  localparam int unsigned SC_W_DEF   = 4;

  localparam int unsigned T_FETCH_LD = 1;
  localparam int unsigned T_DECODE   = 2;

  localparam int unsigned ONEHOT_MAX_W = 256;

  // Callers size-cast the result down to their own one-hot width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] idx);
    logic [ONEHOT_MAX_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Sequence counter SC with combinational one-hot timing outputs T.
// Clear beats enable; the counter wraps naturally at 2**SC_W.
module seq_counter
  import mano_pkg::*;
#(
  parameter int unsigned SC_W = SC_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic                 CLR,
  output logic [SC_W-1:0]      SC,
  output logic [(2**SC_W)-1:0] T
);

  localparam int unsigned TW = 2 ** SC_W;

  logic [SC_W-1:0] sc_q, sc_d;

  always_comb begin
    sc_d = sc_q;
    if (CLR) begin
      sc_d = '0;
    end else if (EN) begin
      sc_d = sc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign SC = sc_q;
  assign T  = TW'(onehot(8'(sc_q)));

endmodule

// File: rtl/ir_seq_ctrl.sv
// Control-unit front end: instruction register, sequence counter and decode latches.
// IR loads at step LOAD_T; opcode/indirect/address latch at step DECODE_T.
module ir_seq_ctrl
  import mano_pkg::*;
#(
  parameter int unsigned WORD_W   = WORD_W_DEF,
  parameter int unsigned OP_W     = OP_W_DEF,
  parameter int unsigned SC_W     = SC_W_DEF,
  parameter int unsigned LOAD_T   = T_FETCH_LD,
  parameter int unsigned DECODE_T = T_DECODE
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      SC_CLR,
  input  logic [WORD_W-1:0]         IN_IR,
  output logic [WORD_W-1:0]         Q_IR,
  output logic [SC_W-1:0]           SC,
  output logic [(2**SC_W)-1:0]      T,
  output logic [(2**OP_W)-1:0]      D,
  output logic                      I_BIT,
  output logic [WORD_W-2-OP_W:0]    ADDR,
  output logic                      IR_VALID
);

  localparam int unsigned DW    = 2 ** OP_W;
  localparam int unsigned ADDRW = WORD_W - 1 - OP_W;

  localparam logic [SC_W-1:0] LOAD_SC   = SC_W'(LOAD_T);
  localparam logic [SC_W-1:0] DECODE_SC = SC_W'(DECODE_T);

  if (!((LOAD_T < DECODE_T) && (DECODE_T < (2 ** SC_W)))) begin : g_bad_timing
    $error("ir_seq_ctrl: need LOAD_T < DECODE_T < 2**SC_W");
  end

  logic [SC_W-1:0] sc;

  seq_counter #(
    .SC_W (SC_W)
  ) u_seq_counter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .CLR   (SC_CLR),
    .SC    (sc),
    .T     (T)
  );

  // Load/decode fire only on an advancing edge; a clear at that step cancels them.
  logic step_ok, load_en, dec_en;

  assign step_ok = EN & ~SC_CLR;
  assign load_en = step_ok & (sc == LOAD_SC);
  assign dec_en  = step_ok & (sc == DECODE_SC);

  logic [WORD_W-1:0] q_ir_q, q_ir_d;
  logic [DW-1:0]     d_q, d_d;
  logic              i_bit_q, i_bit_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic              valid_q, valid_d;

  logic [OP_W-1:0]   op_field;
  logic [DW-1:0]     op_onehot;

  assign op_field  = q_ir_q[WORD_W-2 -: OP_W];
  assign op_onehot = DW'(onehot(8'(op_field)));

  always_comb begin
    q_ir_d  = q_ir_q;
    d_d     = d_q;
    i_bit_d = i_bit_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (load_en) begin
      q_ir_d  = IN_IR;
      valid_d = 1'b0;
    end
    if (dec_en) begin
      i_bit_d = q_ir_q[WORD_W-1];
      d_d     = op_onehot;
      addr_d  = q_ir_q[ADDRW-1:0];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_ir_q  <= '0;
      d_q     <= '0;
      i_bit_q <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      q_ir_q  <= q_ir_d;
      d_q     <= d_d;
      i_bit_q <= i_bit_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign SC       = sc;
  assign Q_IR     = q_ir_q;
  assign D        = d_q;
  assign I_BIT    = i_bit_q;
  assign ADDR     = addr_q;
  assign IR_VALID = valid_q;

endmodule
